// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Accepts MULT/MULTU/DIV/DIVU, holds BUSY for a fixed latency, then commits
// the result to HI/LO. MTHI/MTLO write HI/LO directly when idle.
// Optional feature: define MDU_MADD_EN to add MADD (7) / MADDU (8), which
// accumulate a product into {HI,LO} with multiply latency.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
  localparam int unsigned CntW      = (CntBits > 4) ? CntBits : 4;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       pend_hi_q, pend_lo_q;
  logic              pend_we_q;

  logic              is_mul_op, is_div_op, is_multi;
  logic [63:0]       res;
  logic              res_we;
  logic              done;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_div_s, quot_s, rem_s;
  logic        [31:0] b_div_u, quot_u, rem_u;
  logic               div_ovf;

  // Decode which ops take the multi-cycle path
  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    case (md_op)
      OpMult, OpMultu: is_mul_op = 1'b1;
      OpDiv, OpDivu:   is_div_op = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: is_mul_op = 1'b1;
`endif
      default: ;
    endcase
  end

  assign is_multi = is_mul_op | is_div_op;

  // Arithmetic; divisor is forced to 1 for /0 and for the signed overflow case
  // so the divider never sees an undefined operand (0x80000000 / 1 gives the
  // required quotient 0x80000000 and remainder 0).
  always_comb begin
    a_sx      = {{32{A[31]}}, A};
    b_sx      = {{32{B[31]}}, B};
    prod_s    = a_sx * b_sx;
    prod_u    = {32'd0, A} * {32'd0, B};
    div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    a_s       = $signed(A);
    b_div_s   = ((B == 32'd0) || div_ovf) ? 32'sd1 : $signed(B);
    quot_s    = a_s / b_div_s;
    rem_s     = a_s % b_div_s;
    b_div_u   = (B == 32'd0) ? 32'd1 : B;
    quot_u    = A / b_div_u;
    rem_u     = A % b_div_u;
  end

  // Select the result to park in the pending registers at acceptance
  always_comb begin
    res    = {hi_q, lo_q};
    res_we = 1'b0;
    case (md_op)
      OpMult: begin
        res    = prod_s;
        res_we = 1'b1;
      end
      OpMultu: begin
        res    = prod_u;
        res_we = 1'b1;
      end
      OpDiv: begin
        res    = {rem_s, quot_s};
        res_we = (B != 32'd0);
      end
      OpDivu: begin
        res    = {rem_u, quot_u};
        res_we = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      OpMadd: begin
        res    = {hi_q, lo_q} + prod_s;
        res_we = 1'b1;
      end
      OpMaddu: begin
        res    = {hi_q, lo_q} + prod_u;
        res_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // FSM state and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: load latency on accept, count down in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (is_multi) begin
          state_d = StRun;
          cnt_d   = is_div_op ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    start = 1'b0;
    BUSY  = 1'b0;
    unique case (state_q)
      StIdle:  start = is_multi;
      StRun:   BUSY  = 1'b1;
      default: ;
    endcase
  end

  assign done = (state_q == StRun) && (cnt_q == CntW'(1));

  // Pending result capture, commit at completion, and MTHI/MTLO writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else if (start) begin
      pend_hi_q <= res[63:32];
      pend_lo_q <= res[31:0];
      pend_we_q <= res_we;
    end else if (done) begin
      if (pend_we_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
      pend_we_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (md_op == OpMthi) hi_q <= A;
      if (md_op == OpMtlo) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO are pushed to a
// scoreboard at issue and popped when BUSY falls.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        start, BUSY;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb_q[$];
  logic [63:0] m_hilo;   // bench model of {HI,LO}

  mul_div_unit #(
    .MULT_CYCLES(MulN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .start(start),
    .BUSY (BUSY),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Sign-magnitude reference model
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic [31:0] ma, mb, q, r;
    logic [63:0] p;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = b[31] ? (~b + 32'd1) : b;
    case (op)
      4'd1, 4'd7: begin
        p = {32'd0, ma} * {32'd0, mb};
        if (a[31] ^ b[31]) p = ~p + 64'd1;
        return (op == 4'd7) ? hilo + p : p;
      end
      4'd2, 4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        return (op == 4'd8) ? hilo + p : p;
      end
      4'd3: begin
        if (b == 32'd0) return hilo;
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return hilo;
        return {a % b, a / b};
      end
      default: return hilo;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op in the current cycle; busy_op is held in E while BUSY.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [3:0] busy_op);
    int cyc;
    logic [63:0] held;
    md_op = op;
    A     = a;
    B     = b;
    #1;
    check("start_issue", {63'd0, start}, 64'd1);
    check("idle_issue", {63'd0, BUSY}, 64'd0);
    m_hilo = model(op, a, b, m_hilo);
    sb_q.push_back(m_hilo);
    held = {HI, LO};
    tick();
    md_op = busy_op;
    A     = 32'h0000_1234;
    cyc   = 0;
    while (BUSY && cyc < 100) begin
      #1;
      check("start_busy", {63'd0, start}, 64'd0);
      check("hilo_hold", {HI, LO}, held);
      cyc++;
      tick();
    end
    check("busy_len", 64'(cyc), 64'(n));
    if (sb_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
    else check("hilo_result", {HI, LO}, sb_q.pop_front());
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    md_op = op;
    A     = a;
    tick();
    md_op = 4'd0;
    if (op == 4'd5) m_hilo[63:32] = a;
    else m_hilo[31:0] = a;
    check("mt_write", {HI, LO}, m_hilo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    md_op  = 4'd0;
    A      = '0;
    B      = '0;
    m_hilo = '0;
    #12;
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    md_op = 4'd1;
    #1;
    check("rst_start", {63'd0, start}, 64'd1);
    md_op = 4'd0;
    #1;
    check("rst_start0", {63'd0, start}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, MulN, 4'd0);
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    // MULTU max*max, then DIV held back-to-back behind it
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulN, 4'd3);
    check("multu_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    // DIV -7 / 2 starts in cycle N+1
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, DivN, 4'd0);
    check("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    // DIVU by zero leaves HI/LO untouched
    issue(4'd4, 32'hFFFF_FFF9, 32'd0, DivN, 4'd0);
    check("divz_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    // DIV overflow case
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DivN, 4'd0);
    check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
    issue(4'd4, 32'd100, 32'd7, DivN, 4'd0);
    issue(4'd3, 32'd17, 32'hFFFF_FFFB, DivN, 4'd0);
    issue(4'd1, 32'h7FFF_FFFF, 32'h8000_0000, MulN, 4'd0);

    // MTLO held while BUSY is ignored; the same MTLO lands once BUSY falls
    issue(4'd2, 32'd6, 32'd7, MulN, 4'd6);
    check("mtlo_busy", {32'd0, LO}, 64'd42);
    tick();
    md_op = 4'd0;
    m_hilo[31:0] = 32'h0000_1234;
    check("mtlo_after", {32'd0, LO}, 64'h1234);

    mt(4'd5, 32'hCAFE_0001);
    mt(4'd6, 32'hBEEF_0002);

    // Async reset in the 4th BUSY cycle of a DIV
    md_op = 4'd3;
    A     = 32'd1000;
    B     = 32'd3;
    tick();
    md_op = 4'd0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", {63'd0, BUSY}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", {63'd0, BUSY}, 64'd0);
    check("async_hilo", {HI, LO}, 64'd0);
    m_hilo = '0;
    #3;
    reset = 1'b0;
    tick();
    check("post_rst_idle", {63'd0, BUSY}, 64'd0);
    issue(4'd1, 32'd5, 32'hFFFF_FFFD, MulN, 4'd0);
    check("post_rst_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);

`ifdef MDU_MADD_EN
    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFF_FFFF);
    issue(4'd8, 32'd1, 32'd1, MulN, 4'd0);
    check("maddu_const", {HI, LO}, 64'h0000_0001_0000_0000);
    issue(4'd7, 32'hFFFF_FFFF, 32'd2, MulN, 4'd0);
`else
    md_op = 4'd8;
    A     = 32'd1;
    B     = 32'd1;
    #1;
    check("op8_start", {63'd0, start}, 64'd0);
    tick();
    tick();
    check("op8_busy", {63'd0, BUSY}, 64'd0);
    check("op8_hilo", {HI, LO}, m_hilo);
    md_op = 4'd0;
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
